// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a bounded hold time.
// Grant is kept while the holder requests; it rotates after MAX_HOLD cycles if others wait.
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 gnt_valid_o
);

  localparam int IW = $clog2(N);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    hold_q, hold_d;

  logic [IW:0]   pick;
  logic          others;

  // First requester at or after start, circularly; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(
    input logic [N-1:0] r,
    input int           start
  );
    logic [IW:0] res;
    int          p;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (start + k) % N;
      if (r[p]) res = {1'b1, IW'(p)};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pick    = '0;
    others  = |(req_i & ~gnt_q);
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          pick    = rr_pick(req_i, int'(last_q) + 1);
          state_d = HOLD;
          gnt_d   = N'(1) << pick[IW-1:0];
          id_d    = pick[IW-1:0];
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (req_i[id_q] && !others) begin
          hold_d = '0;
        end else if (req_i[id_q] && hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          // Holder is searched last, so a waiting port always wins.
          pick   = rr_pick(req_i, int'(id_q) + 1);
          last_d = id_q;
          hold_d = '0;
          if (pick[IW]) begin
            gnt_d = N'(1) << pick[IW-1:0];
            id_d  = pick[IW-1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IW'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = |gnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=4, MAX_HOLD=8).
// Steps are applied 1ns after each rising edge; outputs checked there.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       gnt_valid_o;

  int vec = 0;
  int err = 0;
  int wait_cnt [4];
  int max_wait = 0;

  rr_onehot_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] g,
                         input logic [1:0] id, input logic v);
    chk({tag, ".gnt"}, 32'(gnt_o), 32'(g));
    chk({tag, ".id"}, 32'(gnt_id_o), 32'(id));
    chk({tag, ".valid"}, 32'(gnt_valid_o), 32'(v));
  endtask

  initial begin
    reset = 1'b1;
    req_i = 4'b0000;
    tick();
    tick();
    chk_gnt("reset", 4'b0000, 2'd0, 1'b0);

    // requests during reset must not be granted
    req_i = 4'b1010;
    tick();
    chk_gnt("in_reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_gnt("first_gnt", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_gnt("hold_p1", 4'b0010, 2'd1, 1'b1);
    end
    tick();
    chk_gnt("rot_p3", 4'b1000, 2'd3, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_gnt("hold_p3", 4'b1000, 2'd3, 1'b1);
    end
    tick();
    chk_gnt("rot_back_p1", 4'b0010, 2'd1, 1'b1);

    // lone requester keeps the grant
    req_i = 4'b0100;
    tick();
    chk_gnt("lone_first", 4'b0100, 2'd2, 1'b1);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk_gnt("lone_hold", 4'b0100, 2'd2, 1'b1);
    end

    // holder 3 drops with 0 and 1 pending: wrap to 0, no bubble
    req_i = 4'b1000;
    tick();
    chk_gnt("to_p3", 4'b1000, 2'd3, 1'b1);
    req_i = 4'b1011;
    tick();
    chk_gnt("p3_keep", 4'b1000, 2'd3, 1'b1);
    req_i = 4'b0011;
    tick();
    chk_gnt("wrap_p0", 4'b0001, 2'd0, 1'b1);

    // all drop -> idle, last stays 0
    req_i = 4'b0000;
    tick();
    chk_gnt("to_idle", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_gnt("idle_stay", 4'b0000, 2'd0, 1'b0);
    req_i = 4'b1111;
    tick();
    chk_gnt("after_last0", 4'b0010, 2'd1, 1'b1);

    // reset mid-grant
    req_i = 4'b0100;
    tick();
    chk_gnt("pre_rst_p2", 4'b0100, 2'd2, 1'b1);
    req_i = 4'b0101;
    reset = 1'b1;
    tick();
    chk_gnt("mid_reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_gnt("post_reset", 4'b0001, 2'd0, 1'b1);

    // all requesting: strict rotation 0 -> 1 -> 2 -> 3 -> 0
    req_i = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_gnt("all_hold_p0", 4'b0001, 2'd0, 1'b1);
    end
    tick();
    chk_gnt("all_rot_p1", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        if (gnt_o[p]) wait_cnt[p] = 0;
        else wait_cnt[p]++;
        if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
      end
    end
    chk("max_wait", 32'(max_wait), 32'(24));

    // random requests: structural invariants every cycle
    for (int c = 0; c < 10000; c++) begin
      req_i = 4'($urandom_range(0, 15));
      tick();
      chk("onehot0", 32'($onehot0(gnt_o)), 32'd1);
      chk("valid_or", 32'(gnt_valid_o), 32'(|gnt_o));
      chk("id_match", 32'(gnt_id_o),
          gnt_o[3] ? 32'd3 : gnt_o[2] ? 32'd2 : gnt_o[1] ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles for one holder while any other request is pending; legal range 1..255.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 req_i  input  N: per-port request; level-sensitive.
REQ-006 gnt_o  output  N: registered one-hot grant; drives the select input of the downstream one-hot mux.
REQ-007 gnt_id_o  output  clog2(N): binary index of the granted port; valid only when gnt_valid_o=1, else 0.
REQ-008 gnt_valid_o  output  1: high when any gnt_o bit is high (OR-reduction of gnt_o).

Function
REQ-009 gnt_o shall be all-zero or exactly one-hot on every cycle; two or more bits high is forbidden.
REQ-010 State machine states: IDLE (gnt_o=0) and HOLD (one port granted); state, last_q pointer and hold counter hold_q shall be registered.
REQ-011 Latency: a request seen at edge t in IDLE shall produce a grant visible after edge t+1 (one-cycle registered latency); no combinational path from req_i to gnt_o.
REQ-012 IDLE -> HOLD: when req_i != 0, grant the first requesting port in circular order starting at (last_q+1) mod N.
REQ-013 IDLE -> IDLE: when req_i == 0, gnt_o stays 0 and last_q is unchanged.
REQ-014 HOLD, holder req high, no other request pending: keep the grant and hold hold_q saturated at 0 (no forced rotation).
REQ-015 HOLD, holder req high, other request pending: keep the grant and increment hold_q; when hold_q reaches MAX_HOLD-1, move the grant on the next edge to the next requester after the holder in circular order.
REQ-016 HOLD, holder req low: on the next edge, grant the next requester after the holder in circular order with no idle bubble; if none is requesting, go to IDLE.
REQ-017 Each grant change shall set last_q to the index of the port being released and reset hold_q to 0.
REQ-018 Priority search shall wrap from port N-1 to port 0; the holder itself is searched last.
REQ-019 The holder's own request is not re-granted by rotation when any other port is requesting; a lone requester is re-granted continuously.
REQ-020 gnt_id_o and gnt_valid_o shall be consistent with gnt_o in the same cycle (derived from the same register or registered together).
REQ-021 Requests that appear or drop on the same edge as a grant change shall be evaluated with the req_i value sampled at that edge.

Reset
REQ-022 While reset=1 at a clock edge: gnt_o=0, gnt_id_o=0, gnt_valid_o=0, state=IDLE, hold_q=0, last_q=N-1, so port 0 has top priority after reset.
REQ-023 Reset asserted mid-grant shall clear the grant at the same edge, with no further grant while reset=1; the first grant after release follows REQ-011 with last_q=N-1.
REQ-024 Outputs before the first reset edge are unspecified; the bench shall not check them.

Verification
REQ-025 Reset, then req_i=4'b1010 held -> gnt_o=4'b0010 one cycle after reset release; after MAX_HOLD=8 cycles, gnt_o=4'b1000; 8 cycles later, gnt_o=4'b0010.
REQ-026 Single requester req_i=4'b0100 held for 20 cycles -> gnt_o=4'b0100 throughout, with no rotation and gnt_id_o=2.
REQ-027 Holder port 3 drops req while req_i[0] and req_i[1] are high -> next cycle gnt_o=4'b0001 (wrap-around), with no zero cycle.
REQ-028 All requests drop -> next cycle gnt_o=0 and gnt_valid_o=0; then req_i=4'b1111 with last_q=0 -> gnt_o=4'b0010.
REQ-029 reset pulsed for one cycle while gnt_o=4'b0100 -> gnt_o=0 at that edge; with req_i=4'b0101, the first post-reset grant is 4'b0001.
REQ-030 Random req_i for 10k cycles: assert REQ-009 every cycle; with all ports requesting, no port waits more than (N-1)*MAX_HOLD cycles for a grant; gnt_id_o and gnt_valid_o always match gnt_o.
